// File: rtl/sram_256x8_if.sv
// sram_256x8_if: bus bundle for the single-port scratch RAM.
//   dout        read data (driven by the RAM)
//   din         write data
//   addr        word address for read and write
//   wr, rd      write / read strobes, qualified by cs
//   cs          chip select
//   dout_valid  high for the cycle dout carries data from the previous cycle's read
// The master modport is for the requester. The slave modport is for the RAM.
// dout is a net so that it can be tri-stated when SRAM_TRISTATE_EN is defined.
interface sram_256x8_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    wire  [DATA_W-1:0] dout;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              rd;
    logic              cs;
    logic              dout_valid;

    modport master (
        input  dout,
        input  dout_valid,
        output din,
        output addr,
        output wr,
        output rd,
        output cs
    );

    modport slave (
        output dout,
        output dout_valid,
        input  din,
        input  addr,
        input  wr,
        input  rd,
        input  cs
    );
endinterface

// File: rtl/sram_256x8.sv
// sram_256x8: single-port synchronous scratch RAM, 2**ADDR_W words of DATA_W bits.
// Ports:
//   clk  system clock. All state updates on the rising edge.
//   rst  synchronous, active-high reset. Clears dout and dout_valid only.
//   bus  sram_256x8_if.slave, which carries dout, din, addr, wr, rd, cs and dout_valid.
// Writes commit on the edge. Reads are registered with one cycle of latency,
// and dout holds the last read word.
// When wr and rd are asserted together, the write is performed and the read
// returns din (write-through).
// Optional build macro SRAM_TRISTATE_EN: dout is driven only while dout_valid=1
// and is all-Z otherwise. dout_valid is the same in both builds.
module sram_256x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    sram_256x8_if.slave         bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en_p0;
    logic              rd_en_p0;
    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;

    // Input decode. Reset masks both strobes so that no access happens during reset.
    assign wr_en_p0 = !rst && bus.cs && bus.wr;
    assign rd_en_p0 = !rst && bus.cs && bus.rd;

    // Array write. The array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_p0) begin
            mem[bus.addr] <= bus.din;
        end
    end

    // Read register stage p0 -> p1. Write-through bypasses the array so that a
    // simultaneous write and read returns the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_en_p0;
            if (rd_en_p0) begin
                dout_p1 <= bus.wr ? bus.din : mem[bus.addr];
            end
        end
    end

    assign bus.dout_valid = vld_p1;

`ifdef SRAM_TRISTATE_EN
    assign bus.dout = vld_p1 ? dout_p1 : {DATA_W{1'bz}};
`else
    assign bus.dout = dout_p1;
`endif

endmodule

// File: tb/tb_sram_256x8.sv
module tb_sram_256x8;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_256x8_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    sram_256x8 #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, updated by the driver after each rising edge.
    logic [7:0] mem_m [256];
    bit         wrt_m [256];
    logic [7:0] model_dout;
    bit         exp_vld;
    bit         mon_en = 0;
    logic [7:0] exp_q [$];

    // Applies one cycle of stimulus and then advances the model.
    // If hand_en is set, the hand-computed value is queued instead of the model value.
    task automatic step(input bit r, input bit c, input bit w, input bit rr,
                        input logic [7:0] a, input logic [7:0] d,
                        input bit hand_en, input logic [7:0] hand);
        logic [7:0] val;
        rst      = r;
        bus.cs   = c;
        bus.wr   = w;
        bus.rd   = rr;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        if (r) begin
            exp_vld    = 0;
            model_dout = 8'h00;
        end else if (c && rr) begin
            val        = w ? d : (wrt_m[a] ? mem_m[a] : 8'hxx);
            if (hand_en) val = hand;
            exp_q.push_back(val);
            model_dout = val;
            exp_vld    = 1;
        end else begin
            exp_vld = 0;
        end
        if (!r && c && w) begin
            mem_m[a] = d;
            wrt_m[a] = 1;
        end
        #1;
    endtask

    // Monitor: samples on the falling edge. It pops the queue for every valid
    // output and otherwise checks the held (or Z) output.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.dout_valid !== exp_vld) begin
                errors++;
                $display("FAIL dout_valid got %b want %b", bus.dout_valid, exp_vld);
            end
            if (exp_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty got dout=%h want queued entry", bus.dout);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (!$isunknown(e) && bus.dout !== e) begin
                        errors++;
                        $display("FAIL read_data got %h want %h", bus.dout, e);
                    end
                end
            end else begin
                checks++;
`ifdef SRAM_TRISTATE_EN
                if (bus.dout !== 8'hzz) begin
                    errors++;
                    $display("FAIL dout_z got %h want zz", bus.dout);
                end
`else
                if (bus.dout !== model_dout) begin
                    errors++;
                    $display("FAIL dout_hold got %h want %h", bus.dout, model_dout);
                end
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) wrt_m[i] = 0;
        // Power-up reset, then seed addr 0 so that the reset test has a known value.
        step(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        mon_en = 1;
        step(0, 1, 1, 0, 8'h00, 8'h33, 0, 8'h00);
        // Reset for two cycles with a write attempt that must be ignored.
        step(1, 1, 1, 0, 8'h00, 8'hFF, 0, 8'h00);
        step(1, 1, 1, 0, 8'h00, 8'hFF, 0, 8'h00);
        step(0, 1, 0, 1, 8'h00, 8'h00, 1, 8'h33);
        // Write then read.
        step(0, 1, 1, 0, 8'h5A, 8'hA5, 0, 8'h00);
        step(0, 1, 0, 1, 8'h5A, 8'h00, 1, 8'hA5);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        // Chip-select gating.
        step(0, 1, 1, 0, 8'hA5, 8'h11, 0, 8'h00);
        step(0, 0, 1, 0, 8'hA5, 8'h3C, 0, 8'h00);
        step(0, 0, 1, 1, 8'hA5, 8'h3C, 0, 8'h00);
        step(0, 1, 0, 1, 8'hA5, 8'h00, 1, 8'h11);
        // Write-through, then a plain read of the same address.
        step(0, 1, 1, 1, 8'h10, 8'h77, 1, 8'h77);
        step(0, 1, 0, 0, 8'h10, 8'h00, 0, 8'h00);
        step(0, 1, 0, 1, 8'h10, 8'h00, 1, 8'h77);
        // Address boundaries and back-to-back reads.
        step(0, 1, 1, 0, 8'h00, 8'h01, 0, 8'h00);
        step(0, 1, 1, 0, 8'hFF, 8'hFE, 0, 8'h00);
        step(0, 1, 0, 1, 8'h00, 8'h00, 1, 8'h01);
        step(0, 1, 0, 1, 8'hFF, 8'h00, 1, 8'hFE);
        // Reset in the middle of operation after a read.
        step(0, 1, 0, 1, 8'h5A, 8'h00, 1, 8'hA5);
        step(1, 1, 0, 1, 8'h5A, 8'h00, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        // Preload a small address window with distinct values for the soak.
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 8'(i + 32), 8'(i * 13 + 5), 0, 8'h00);
        // Random soak: fixed din, random strobes, occasional reset.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(32, 47)), 8'h5C, 0, 8'h00);
        end
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        @(negedge clk);
        #1;
        mon_en = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
